// File: rtl/ysyx_23060221_lsu_if.sv
// Memory bus between the LSU and the data memory subsystem.
// The request channel and the response channel each use a valid/ready handshake.
interface ysyx_23060221_lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_wen;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wstrb;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic [DW-1:0]   mem_rsp_rdata;
  logic            mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/ysyx_23060221_lsu.sv
// Load/store unit between EXU and WBU.
// Accepts one instruction per handshake, issues at most one memory request,
// aligns and extends load data, then presents the result to WBU.
// Optional feature: define LSU_MISALIGN_CHECK_EN to trap misaligned half/word
// accesses locally (no bus request) and expose the lsu_misalign flag.
module ysyx_23060221_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EXU_valid,
  output logic          LSU_ready,
  input  logic [AW-1:0] res_in,
  input  logic [DW-1:0] wdata,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [2:0]    funct3,
  input  logic          memtoreg_in,
  input  logic          regw_in,
  output logic          LSU_valid,
  input  logic          WBU_ready,
  output logic [AW-1:0] res,
  output logic [DW-1:0] dataout,
  output logic          memtoreg,
  output logic          regw,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic          lsu_misalign,
`endif
  ysyx_23060221_lsu_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   res_q, res_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            wen_q, wen_d;
  logic [2:0]      f3_q, f3_d;
  logic            memtoreg_q, memtoreg_d;
  logic            regw_q, regw_d;
  logic [DW-1:0]   dataout_q, dataout_d;
`ifdef LSU_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
`endif

  // Byte strobes for a store; bits shifted past the top lane are dropped.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate store data so the selected lanes carry it regardless of offset.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Shift the addressed bytes down and sign/zero extend; unknown sizes act as word.
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] r;
    logic [31:0] o;
    r = d >> {a, 3'b000};
    case (f3)
      3'b000:  o = {{24{r[7]}}, r[7:0]};
      3'b001:  o = {{16{r[15]}}, r[15:0]};
      3'b100:  o = {24'd0, r[7:0]};
      3'b101:  o = {16'd0, r[15:0]};
      default: o = r;
    endcase
    return o;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  // Halfwords need a[0]=0, words (and unknown sizes) need a[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction
`endif

  // State and captured transaction registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      res_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wen_q      <= 1'b0;
      f3_q       <= 3'd0;
      memtoreg_q <= 1'b0;
      regw_q     <= 1'b0;
      dataout_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wen_q      <= wen_d;
      f3_q       <= f3_d;
      memtoreg_q <= memtoreg_d;
      regw_q     <= regw_d;
      dataout_q  <= dataout_d;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state logic: capture in IDLE, handshake through REQ/RSP, hold result in DONE.
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wen_d      = wen_q;
    f3_d       = f3_q;
    memtoreg_d = memtoreg_q;
    regw_d     = regw_q;
    dataout_d  = dataout_q;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (EXU_valid) begin
          res_d      = res_in;
          memtoreg_d = memtoreg_in;
          regw_d     = regw_in;
          f3_d       = funct3;
          wen_d      = memwrite;
          dataout_d  = '0;
          wdata_d    = store_data(funct3, wdata);
          wstrb_d    = memwrite ? store_strb(funct3, res_in[1:0]) : 4'b0000;
          if (memwrite || memread) begin
`ifdef LSU_MISALIGN_CHECK_EN
            if (is_misaligned(funct3, res_in[1:0])) begin
              state_d    = S_DONE;
              regw_d     = 1'b0;
              misalign_d = 1'b1;
            end else begin
              state_d = S_REQ;
            end
`else
            state_d = S_REQ;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) state_d = S_RSP;
      end
      S_RSP: begin
        if (mem.mem_rsp_valid) begin
          state_d = S_DONE;
          if (mem.mem_rsp_err) begin
            dataout_d = '0;
            regw_d    = 1'b0;
          end else if (!wen_q) begin
            dataout_d = load_align(f3_q, res_q[1:0], mem.mem_rsp_rdata);
          end
        end
      end
      S_DONE: begin
        if (WBU_ready) begin
          state_d = S_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
          misalign_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign LSU_ready = (state_q == S_IDLE) && !rst;
  assign LSU_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign dataout   = dataout_q;
  assign memtoreg  = memtoreg_q;
  assign regw      = regw_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign lsu_misalign = misalign_q;
`endif

  assign mem.mem_req_valid = (state_q == S_REQ);
  assign mem.mem_req_addr  = {res_q[AW-1:2], 2'b00};
  assign mem.mem_req_wen   = wen_q;
  assign mem.mem_req_wdata = wdata_q;
  assign mem.mem_req_wstrb = wstrb_q;
  assign mem.mem_rsp_ready = (state_q == S_RSP);

endmodule
